// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth digit decoder for the multiplier.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_t;

    typedef enum logic [2:0] {B_ZERO, B_PM, B_P2M, B_NM, B_N2M} booth_sel_t;

    // Map a {q[i+1], q[i], q[i-1]} window to the partial-product selection.
    function automatic booth_sel_t booth_decode(logic [2:0] win);
        booth_sel_t sel;
        case (win)
            3'b000, 3'b111: sel = B_ZERO;
            3'b001, 3'b010: sel = B_PM;
            3'b011:         sel = B_P2M;
            3'b100:         sel = B_N2M;
            default:        sel = B_NM;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_radix4_multiplier_if.sv
// Request/response bundle of the Booth multiplier; clock and reset stay outside.
interface booth_radix4_multiplier_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   S;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, S
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, S
    );
endinterface

// File: rtl/booth_recoder.sv
// Turns a 3-bit Booth window and the extended multiplicand into the signed addend.
module booth_recoder
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]       win_i,
    input  logic [WIDTH+2:0] m_i,
    output logic [WIDTH+2:0] addend_o
);

    logic [WIDTH+2:0] m2;
    assign m2 = {m_i[WIDTH+1:0], 1'b0};

    // Select 0, +-M or +-2M; negation wraps modulo 2^(WIDTH+3).
    always_comb begin
        addend_o = '0;
        case (booth_decode(win_i))
            B_PM:    addend_o = m_i;
            B_P2M:   addend_o = m2;
            B_NM:    addend_o = -m_i;
            B_N2M:   addend_o = -m2;
            default: addend_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Self-sequenced radix-4 Booth multiplier, two multiplier bits retired per cycle.
module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                          CLOCK,
    input  logic                          RESET,
    booth_radix4_multiplier_if.slave      bus
);

    localparam int unsigned NumIter = WIDTH / 2 + 1;
    localparam int unsigned CntW    = $clog2(NumIter + 1);
    localparam int unsigned HiW     = WIDTH + 3;
    localparam int unsigned LoW     = WIDTH + 2;

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("booth_radix4_multiplier: WIDTH must be even and >= 4");
    end

    booth_state_t       state_q, state_d;
    logic [HiW-1:0]     m_q, m_d;
    logic [HiW-1:0]     hi_q, hi_d;
    logic [LoW-1:0]     lo_q, lo_d;
    logic               x_q, x_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [2*WIDTH-1:0] s_q, s_d;

    logic [HiW-1:0]     addend;
    logic [HiW-1:0]     hi_sum;
    logic [HiW+LoW:0]   cat;
    logic [HiW+LoW:0]   sh;
    logic [LoW-1:0]     a_ext;
    logic [HiW-1:0]     b_ext;
    logic               last_iter;

    booth_recoder #(
        .WIDTH (WIDTH)
    ) u_recoder (
        .win_i    ({lo_q[1:0], x_q}),
        .m_i      (m_q),
        .addend_o (addend)
    );

    // Accumulate, then arithmetic-shift {HI,LO,x} right by one radix-4 digit.
    always_comb begin
        hi_sum    = hi_q + addend;
        cat       = {hi_sum, lo_q, x_q};
        sh        = {{2{hi_sum[HiW-1]}}, cat[HiW+LoW:2]};
        a_ext     = {{2{bus.signed_mode & bus.A[WIDTH-1]}}, bus.A};
        b_ext     = {{3{bus.signed_mode & bus.B[WIDTH-1]}}, bus.B};
        last_iter = (count_q == CntW'(NumIter - 1));
    end

    // Controller and datapath next-state.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        x_d     = x_q;
        count_d = count_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = b_ext;
                    lo_d    = a_ext;
                    hi_d    = '0;
                    x_d     = 1'b0;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                hi_d    = sh[HiW+LoW:LoW+1];
                lo_d    = sh[LoW:1];
                x_d     = sh[0];
                count_d = count_q + CntW'(1);
                if (last_iter) begin
                    // Product is the low 2*WIDTH bits of the shifted {HI,LO}.
                    s_d     = sh[2*WIDTH:1];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            x_q     <= 1'b0;
            count_q <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            x_q     <= x_d;
            count_q <= count_d;
            s_q     <= s_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.S    = s_q;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Directed and random checks of the WIDTH=8 Booth multiplier against an A*B model.
module tb_booth_radix4_multiplier;

    localparam int unsigned W       = 8;
    localparam int unsigned NumIter = W / 2 + 1;

    typedef struct {
        logic [2*W-1:0] s;
        int unsigned    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    booth_radix4_multiplier_if #(.WIDTH(W)) bus ();

    booth_radix4_multiplier #(
        .WIDTH (W)
    ) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cycle  = 0;
    exp_t        sb[$];
    logic        rst_at_edge;
    logic        prev_done;
    logic [2*W-1:0] prev_s;

    function automatic logic [2*W-1:0] model(logic m, logic [W-1:0] a, logic [W-1:0] b);
        logic signed [2*W-1:0] sp;
        logic [2*W-1:0]        up;
        sp = $signed(a) * $signed(b);
        up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return m ? sp : up;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Advance one clock, sample 1 ns after the edge, check protocol and scoreboard.
    task automatic tick();
        rst_at_edge = rst;
        prev_s      = bus.S;
        prev_done   = bus.done;
        @(posedge clk);
        #1;
        cycle++;
        if (rst_at_edge) begin
            check("reset_s", 32'(bus.S), 32'h0);
            check("reset_busy", 32'(bus.busy), 32'h0);
            check("reset_done", 32'(bus.done), 32'h0);
        end else begin
            if (bus.done) begin
                check("done_implies_busy", 32'(bus.busy), 32'h1);
                check("done_single_pulse", 32'(prev_done), 32'h0);
                if (sb.size() == 0) begin
                    check("spurious_done", 32'(bus.done), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", 32'(bus.S), 32'(e.s));
                    check("done_cycle", cycle, e.cyc);
                end
            end else begin
                check("s_stable", 32'(bus.S), 32'(prev_s));
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 50) begin
            tick();
            n++;
        end
        check("idle_wait", 32'(bus.busy), 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'h0);
    endtask

    // One accepted operation: drive start for exactly one cycle from IDLE.
    task automatic do_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        bus.signed_mode = m;
        bus.A           = a;
        bus.B           = b;
        bus.start       = 1'b1;
        sb.push_back('{s: model(m, a, b), cyc: cycle + NumIter + 1});
        tick();
        bus.start       = 1'b0;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.A           = '0;
        bus.B           = '0;
        prev_done       = 1'b0;
        prev_s          = '0;

        // Reset state.
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(bus.busy), 32'h0);
        check("idle_s", 32'(bus.S), 32'h0);

        // Boundary and directed products.
        do_op(1'b0, 8'd255, 8'd255);
        drain();
        do_op(1'b1, 8'h80, 8'h80);
        drain();
        do_op(1'b1, 8'hFF, 8'd5);
        drain();
        do_op(1'b1, 8'd0, 8'(-77));
        drain();
        do_op(1'b0, 8'h80, 8'hFF);
        drain();
        do_op(1'b1, 8'h7F, 8'h80);
        drain();

        // Random mixed-mode operations.
        for (int i = 0; i < 60; i++) begin
            do_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end
        drain();

        // Start held high: accepted every NumIter+2 cycles, in-flight input changes ignored.
        wait_idle();
        bus.start = 1'b1;
        for (int i = 0; i < 5 * (NumIter + 2); i++) begin
            bus.signed_mode = 1'($urandom_range(0, 1));
            bus.A           = 8'($urandom);
            bus.B           = 8'($urandom);
            if (i % (NumIter + 2) == 0) begin
                sb.push_back('{s: model(bus.signed_mode, bus.A, bus.B),
                               cyc: cycle + NumIter + 1});
            end
            tick();
        end
        bus.start = 1'b0;
        drain();

        // Reset in CALC iteration 2: abort, S cleared, no done pulse.
        do_op(1'b0, 8'd3, 8'd7);
        drain();
        wait_idle();
        bus.A     = 8'd99;
        bus.B     = 8'd77;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("busy_in_calc", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("idle_after_abort", 32'(bus.busy), 32'h0);
        check("s_after_abort", 32'(bus.S), 32'h0);

        // Reset dominates start in the same cycle.
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (8) tick();
        check("reset_over_start", 32'(bus.busy), 32'h0);

        // Recovery after abort.
        do_op(1'b1, 8'd200, 8'd7);
        drain();
        do_op(1'b0, 8'd200, 8'd7);
        drain();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
